// File: rtl/pio_host.sv
// pio_host -- host side of a nibble-out / byte-in parallel peer port.
// Sends a byte as three strobed nibble phases (command, low, high) and reads
// a byte by polling the peer status, issuing a data command, sampling the
// returned byte and acknowledging it with a final strobe.
// Optional feature: define PIO_HOST_POLL_EN to re-sample an empty peer
// status up to POLL_MAX times before giving up; without it the first empty
// status ends the read.
module pio_host #(
  parameter int STB_LEN  = 2,   // strobe width in clocks, 1..15
  parameter int SETTLE   = 2,   // clocks from command to response sample, 1..15
  parameter int POLL_MAX = 255  // maximum status re-polls, 1..255
) (
  input  logic       iClk,
  input  logic       iRst,
  output logic [3:0] oPData,
  output logic [4:0] oCtrl,
  input  logic [7:0] iPData,
  input  logic       iTxReq,
  input  logic [7:0] iTxData,
  input  logic       iRxReq,
  output logic       oBusy,
  output logic       oTxDone,
  output logic       oRxValid,
  output logic [7:0] oRxData,
  output logic [3:0] oRxPort,
  output logic       oRxEmpty
);

  // Command nibbles understood by the peer.
  localparam logic [3:0] CMD_W_DATA = 4'h2;
  localparam logic [3:0] CMD_R_PORT = 4'h9;
  localparam logic [3:0] CMD_R_DATA = 4'hA;

  // Strobe encodings; bit 4 (Clear) is never driven.
  localparam logic [4:0] CTRL_IDLE = 5'b00000;
  localparam logic [4:0] CTRL_CMD  = 5'b00010;
  localparam logic [4:0] CTRL_LO   = 5'b00101;
  localparam logic [4:0] CTRL_HI   = 5'b01000;
  localparam logic [4:0] CTRL_ACK  = 5'b01001;

  // Counter reload values: the counter runs from N-1 down to 0, giving N clocks.
  localparam logic [3:0] STB_LOAD    = 4'(STB_LEN - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  // Elaboration-time guards on the legal parameter ranges.
  if (STB_LEN < 1 || STB_LEN > 15) begin : g_chk_stb_len
    $error("pio_host: STB_LEN must be in 1..15");
  end
  if (SETTLE < 1 || SETTLE > 15) begin : g_chk_settle
    $error("pio_host: SETTLE must be in 1..15");
  end
  if (POLL_MAX < 1 || POLL_MAX > 255) begin : g_chk_poll_max
    $error("pio_host: POLL_MAX must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,   // nibble on the bus, strobe idle
    S_STROBE,  // strobe encoding driven for STB_LEN clocks
    S_HOLD,    // strobe idle, nibble still held
    S_SETTLE,  // wait for the peer to answer a read command
    S_SAMPLE,  // capture iPData
    S_DONE     // one-clock completion pulse
  } state_t;

  // Which bus phase of the transaction is in progress.
  typedef enum logic [2:0] {
    TX_CMD,
    TX_LO,
    TX_HI,
    RX_CMDP,
    RX_CMDD,
    RX_ACK
  } step_t;

  state_t     r_state,   w_state_nxt;
  step_t      r_step,    w_step_nxt;
  logic [3:0] r_cnt,     w_cnt_nxt;
  logic [7:0] r_txdata,  w_txdata_nxt;
  logic [3:0] r_pdata,   w_pdata_nxt;
  logic [7:0] r_rxdata,  w_rxdata_nxt;
  logic [3:0] r_rxport,  w_rxport_nxt;
  logic       r_rxempty, w_rxempty_nxt;
`ifdef PIO_HOST_POLL_EN
  localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);
  logic [7:0] r_poll, w_poll_nxt;
`endif

  // Next-state and next-register logic for the transaction sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can leave it unassigned, which would infer a latch.
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_cnt_nxt     = r_cnt;
    w_txdata_nxt  = r_txdata;
    w_pdata_nxt   = r_pdata;
    w_rxdata_nxt  = r_rxdata;
    w_rxport_nxt  = r_rxport;
    w_rxempty_nxt = r_rxempty;
`ifdef PIO_HOST_POLL_EN
    w_poll_nxt    = r_poll;
`endif

    case (r_state)
      S_IDLE: begin
        // Transmit has priority; a simultaneous read request is dropped.
        if (iTxReq) begin
          w_txdata_nxt = iTxData;
          w_step_nxt   = TX_CMD;
          w_pdata_nxt  = CMD_W_DATA;
          w_state_nxt  = S_SETUP;
        end else if (iRxReq) begin
          w_step_nxt    = RX_CMDP;
          w_pdata_nxt   = CMD_R_PORT;
          w_rxdata_nxt  = 8'h00;
          w_rxport_nxt  = 4'h0;
          w_rxempty_nxt = 1'b0;
`ifdef PIO_HOST_POLL_EN
          w_poll_nxt    = 8'h00;
`endif
          w_state_nxt   = S_SETUP;
        end
      end

      S_SETUP: begin
        w_cnt_nxt   = STB_LOAD;
        w_state_nxt = S_STROBE;
      end

      S_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      S_HOLD: begin
        case (r_step)
          TX_CMD: begin
            w_step_nxt  = TX_LO;
            w_pdata_nxt = r_txdata[3:0];
            w_state_nxt = S_SETUP;
          end
          TX_LO: begin
            w_step_nxt  = TX_HI;
            w_pdata_nxt = r_txdata[7:4];
            w_state_nxt = S_SETUP;
          end
          RX_CMDP, RX_CMDD: begin
            w_cnt_nxt   = SETTLE_LOAD;
            w_state_nxt = S_SETTLE;
          end
          default: begin
            // TX_HI and RX_ACK are the last phases of their transactions.
            w_state_nxt = S_DONE;
          end
        endcase
      end

      S_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      S_SAMPLE: begin
        if (r_step == RX_CMDP) begin
          if (iPData[7]) begin
`ifdef PIO_HOST_POLL_EN
            if (r_poll < POLL_LIMIT) begin
              // Re-sample the status without resending the command.
              w_poll_nxt  = r_poll + 8'd1;
              w_cnt_nxt   = SETTLE_LOAD;
              w_state_nxt = S_SETTLE;
            end else begin
              w_rxdata_nxt  = 8'h00;
              w_rxempty_nxt = 1'b1;
              w_state_nxt   = S_DONE;
            end
`else
            w_rxdata_nxt  = 8'h00;
            w_rxempty_nxt = 1'b1;
            w_state_nxt   = S_DONE;
`endif
          end else begin
            w_rxport_nxt = iPData[3:0];
            w_step_nxt   = RX_CMDD;
            w_pdata_nxt  = CMD_R_DATA;
            w_state_nxt  = S_SETUP;
          end
        end else begin
          // Data sample; the ACK phase keeps the R_DATA nibble on the bus.
          w_rxdata_nxt  = iPData;
          w_rxempty_nxt = 1'b0;
          w_step_nxt    = RX_ACK;
          w_pdata_nxt   = CMD_R_DATA;
          w_state_nxt   = S_SETUP;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge iClk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (iRst) begin
      r_state   <= S_IDLE;
      r_step    <= TX_CMD;
      r_cnt     <= 4'd0;
      r_txdata  <= 8'h00;
      r_pdata   <= 4'h0;
      r_rxdata  <= 8'h00;
      r_rxport  <= 4'h0;
      r_rxempty <= 1'b0;
`ifdef PIO_HOST_POLL_EN
      r_poll    <= 8'h00;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_cnt     <= w_cnt_nxt;
      r_txdata  <= w_txdata_nxt;
      r_pdata   <= w_pdata_nxt;
      r_rxdata  <= w_rxdata_nxt;
      r_rxport  <= w_rxport_nxt;
      r_rxempty <= w_rxempty_nxt;
`ifdef PIO_HOST_POLL_EN
      r_poll    <= w_poll_nxt;
`endif
    end
  end

  // Strobe bus decode: only the STROBE state drives an encoding.
  always_comb begin
    oCtrl = CTRL_IDLE;
    if (r_state == S_STROBE) begin
      case (r_step)
        TX_LO:   oCtrl = CTRL_LO;
        TX_HI:   oCtrl = CTRL_HI;
        RX_ACK:  oCtrl = CTRL_ACK;
        default: oCtrl = CTRL_CMD;
      endcase
    end
  end

  assign oPData   = r_pdata;
  assign oBusy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign oTxDone  = (r_state == S_DONE) && (r_step == TX_HI);
  assign oRxValid = (r_state == S_DONE) && (r_step != TX_HI);
  assign oRxData  = r_rxdata;
  assign oRxPort  = r_rxport;
  assign oRxEmpty = r_rxempty;

endmodule

// File: tb/tb_pio_host.sv
// tb_pio_host -- scoreboard bench for pio_host: expected completions are
// queued when a request is driven and compared when the DUT pulses done;
// a negedge monitor records every strobe on oCtrl with its nibble and width.
`timescale 1ns/1ps
module tb_pio_host;

  localparam int POLL_TB = 3;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [3:0] oPData;
  logic [4:0] oCtrl;
  logic [7:0] iPData;
  logic       iTxReq = 1'b0;
  logic [7:0] iTxData = 8'h00;
  logic       iRxReq = 1'b0;
  logic       oBusy, oTxDone, oRxValid;
  logic [7:0] oRxData;
  logic [3:0] oRxPort;
  logic       oRxEmpty;

  // Peer model: status answers the R_PORT command, data answers anything else.
  logic [7:0] peer_status = 8'h00;
  logic [7:0] peer_data   = 8'h00;
  assign iPData = (oPData == 4'h9) ? peer_status : peer_data;

  pio_host #(.STB_LEN(2), .SETTLE(2), .POLL_MAX(POLL_TB)) dut (
    .iClk(iClk), .iRst(iRst), .oPData(oPData), .oCtrl(oCtrl), .iPData(iPData),
    .iTxReq(iTxReq), .iTxData(iTxData), .iRxReq(iRxReq), .oBusy(oBusy),
    .oTxDone(oTxDone), .oRxValid(oRxValid), .oRxData(oRxData),
    .oRxPort(oRxPort), .oRxEmpty(oRxEmpty)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [4:0] ctl;
    logic [3:0] pd;
    logic [7:0] len;
    logic       pd_stable;
  } strobe_t;

  typedef struct packed {
    logic        tx;
    logic        rx;
    logic [7:0]  data;
    logic [3:0]  port;
    logic        empty;
    logic        busy;
    logic [63:0] t;
  } done_t;

  typedef struct packed {
    logic            is_tx;
    logic [7:0]      lat;
    logic [7:0]      data;
    logic [3:0]      port;
    logic            empty;
    logic [1:0]      ns;
    logic [2:0][4:0] ctl;
    logic [2:0][3:0] pd;
  } exp_t;

  strobe_t sq[$];
  done_t   dq[$];
  exp_t    eq[$];
  int      n_cmp = 0;
  int      n_mis = 0;

  logic       have_last = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [3:0] last_port = 4'h0;

  // Monitor: group consecutive equal non-idle oCtrl samples into strobes, log done pulses.
  strobe_t    cur = '0;
  logic [4:0] prev_ctl = 5'b0;
  always @(negedge iClk) begin
    if (iRst) begin
      prev_ctl = 5'b0;
    end else begin
      if (oCtrl != 5'b0 && oCtrl == prev_ctl) begin
        cur.len = cur.len + 8'd1;
        if (oPData != cur.pd) cur.pd_stable = 1'b0;
      end else begin
        if (prev_ctl != 5'b0) sq.push_back(cur);
        if (oCtrl != 5'b0) begin
          cur.ctl = oCtrl; cur.pd = oPData; cur.len = 8'd1; cur.pd_stable = 1'b1;
        end
      end
      prev_ctl = oCtrl;
      if (oTxDone || oRxValid)
        dq.push_back('{tx: oTxDone, rx: oRxValid, data: oRxData, port: oRxPort,
                       empty: oRxEmpty, busy: oBusy, t: $time});
    end
  end

  // Bounded wait for the next completion pulse.
  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge iClk); #1;
      if (dq.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iTxReq = 1'b1; iTxData = 8'hFF; iRxReq = 1'b1;
    repeat (3) @(negedge iClk);
    n_cmp++; if (oCtrl !== 5'b0)    begin n_mis++; $display("FAIL reset_ctrl: got %b want 00000", oCtrl); end
    n_cmp++; if (oPData !== 4'h0)   begin n_mis++; $display("FAIL reset_pdata: got %h want 0", oPData); end
    n_cmp++; if (oBusy !== 1'b0)    begin n_mis++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    n_cmp++; if (oTxDone !== 1'b0)  begin n_mis++; $display("FAIL reset_txdone: got %b want 0", oTxDone); end
    n_cmp++; if (oRxValid !== 1'b0) begin n_mis++; $display("FAIL reset_rxvalid: got %b want 0", oRxValid); end
    n_cmp++; if (oRxData !== 8'h00) begin n_mis++; $display("FAIL reset_rxdata: got %h want 00", oRxData); end
    n_cmp++; if (oRxPort !== 4'h0)  begin n_mis++; $display("FAIL reset_rxport: got %h want 0", oRxPort); end
    n_cmp++; if (oRxEmpty !== 1'b0) begin n_mis++; $display("FAIL reset_rxempty: got %b want 0", oRxEmpty); end
    iTxReq = 1'b0; iRxReq = 1'b0;
  endtask

  // Send one byte; also releases reset in the same clock as the request.
  task automatic test_send(input logic [7:0] d);
    exp_t e; done_t ev; logic [63:0] t_acc; bit ok; int lat;
    e = '0; e.is_tx = 1'b1; e.lat = 8'd12; e.ns = 2'd3;
    e.ctl[0] = 5'b00010; e.pd[0] = 4'h2;
    e.ctl[1] = 5'b00101; e.pd[1] = d[3:0];
    e.ctl[2] = 5'b01000; e.pd[2] = d[7:4];
    sq.delete(); dq.delete(); eq.delete(); eq.push_back(e);
    @(negedge iClk); iRst = 1'b0; iTxReq = 1'b1; iTxData = d;
    @(posedge iClk); t_acc = $time; #1; iTxReq = 1'b0; iTxData = ~d;
    @(negedge iClk);
    n_cmp++; if (oBusy !== 1'b1) begin n_mis++; $display("FAIL send_busy_rise: got %b want 1", oBusy); end
    wait_done(40, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL send_done_timeout: got none want oTxDone"); end
    else begin
      ev = dq.pop_front(); e = eq.pop_front();
      lat = int'((ev.t - t_acc - 64'd5) / 64'd10);
      n_cmp++; if (ev.tx !== e.is_tx || ev.rx !== 1'b0) begin n_mis++; $display("FAIL send_pulse: got tx=%b rx=%b want tx=1 rx=0", ev.tx, ev.rx); end
      n_cmp++; if (lat != int'(e.lat)) begin n_mis++; $display("FAIL send_latency: got %0d want %0d", lat, e.lat); end
      n_cmp++; if (ev.busy !== 1'b0) begin n_mis++; $display("FAIL send_busy_fall: got %b want 0", ev.busy); end
      n_cmp++; if (sq.size() != int'(e.ns)) begin n_mis++; $display("FAIL send_strobe_count: got %0d want %0d", sq.size(), e.ns); end
      for (int i = 0; i < 3; i++) begin
        if (i < sq.size()) begin
          n_cmp++;
          if (sq[i].ctl !== e.ctl[i] || sq[i].pd !== e.pd[i] || sq[i].len !== 8'd2 || sq[i].pd_stable !== 1'b1) begin
            n_mis++;
            $display("FAIL send_strobe%0d: got %b/%h len %0d stable %b want %b/%h len 2 stable 1",
                     i, sq[i].ctl, sq[i].pd, sq[i].len, sq[i].pd_stable, e.ctl[i], e.pd[i]);
          end
        end
      end
    end
    @(negedge iClk);
    n_cmp++; if (oPData !== d[7:4] || oBusy !== 1'b0) begin n_mis++; $display("FAIL send_idle_hold: got pdata=%h busy=%b want %h 0", oPData, oBusy, d[7:4]); end
  endtask

  // One read with a fixed peer status and data byte.
  task automatic test_read(input logic [7:0] st, input logic [7:0] dt);
    exp_t e; done_t ev; logic [63:0] t_acc; bit ok; int lat;
    e = '0; e.is_tx = 1'b0;
    if (st[7]) begin
      e.empty = 1'b1; e.data = 8'h00; e.ns = 2'd1;
      e.ctl[0] = 5'b00010; e.pd[0] = 4'h9;
`ifdef PIO_HOST_POLL_EN
      e.lat = 8'(4 + 3 * (POLL_TB + 1));
`else
      e.lat = 8'd7;
`endif
    end else begin
      e.empty = 1'b0; e.data = dt; e.port = st[3:0]; e.lat = 8'd18; e.ns = 2'd3;
      e.ctl[0] = 5'b00010; e.pd[0] = 4'h9;
      e.ctl[1] = 5'b00010; e.pd[1] = 4'hA;
      e.ctl[2] = 5'b01001; e.pd[2] = 4'hA;
    end
    if (have_last) begin
      n_cmp++; if (oRxData !== last_data || oRxPort !== last_port) begin n_mis++; $display("FAIL read_result_held: got %h/%h want %h/%h", oRxData, oRxPort, last_data, last_port); end
    end
    sq.delete(); dq.delete(); eq.delete(); eq.push_back(e);
    peer_status = st; peer_data = dt;
    @(negedge iClk); iRxReq = 1'b1;
    @(posedge iClk); t_acc = $time; #1; iRxReq = 1'b0;
    wait_done(60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL read_done_timeout: got none want oRxValid"); end
    else begin
      ev = dq.pop_front(); e = eq.pop_front();
      lat = int'((ev.t - t_acc - 64'd5) / 64'd10);
      n_cmp++; if (ev.rx !== 1'b1 || ev.tx !== 1'b0) begin n_mis++; $display("FAIL read_pulse: got tx=%b rx=%b want tx=0 rx=1", ev.tx, ev.rx); end
      n_cmp++; if (lat != int'(e.lat)) begin n_mis++; $display("FAIL read_latency: got %0d want %0d", lat, e.lat); end
      n_cmp++; if (ev.data !== e.data || ev.empty !== e.empty) begin n_mis++; $display("FAIL read_result: got data=%h empty=%b want %h %b", ev.data, ev.empty, e.data, e.empty); end
      if (!e.empty) begin
        n_cmp++; if (ev.port !== e.port) begin n_mis++; $display("FAIL read_port: got %h want %h", ev.port, e.port); end
      end
      n_cmp++; if (ev.busy !== 1'b0) begin n_mis++; $display("FAIL read_busy_fall: got %b want 0", ev.busy); end
      n_cmp++; if (sq.size() != int'(e.ns)) begin n_mis++; $display("FAIL read_strobe_count: got %0d want %0d", sq.size(), e.ns); end
      for (int i = 0; i < 3; i++) begin
        if (i < sq.size()) begin
          n_cmp++;
          if (sq[i].ctl !== e.ctl[i] || sq[i].pd !== e.pd[i] || sq[i].len !== 8'd2) begin
            n_mis++;
            $display("FAIL read_strobe%0d: got %b/%h len %0d want %b/%h len 2", i, sq[i].ctl, sq[i].pd, sq[i].len, e.ctl[i], e.pd[i]);
          end
        end
      end
    end
    have_last = !st[7]; last_data = dt; last_port = st[3:0];
  endtask

  // Simultaneous requests, then requests during busy that must be ignored.
  task automatic test_collision();
    exp_t e; done_t ev; logic [63:0] t_acc; bit ok; int lat;
    e = '0; e.is_tx = 1'b1; e.lat = 8'd12; e.ns = 2'd3;
    sq.delete(); dq.delete(); eq.delete(); eq.push_back(e);
    peer_status = 8'h01; peer_data = 8'h11;
    @(negedge iClk); iTxReq = 1'b1; iRxReq = 1'b1; iTxData = 8'h3E;
    @(posedge iClk); t_acc = $time; #1; iTxReq = 1'b0; iRxReq = 1'b0;
    repeat (2) @(negedge iClk);
    iTxReq = 1'b1; iRxReq = 1'b1; iTxData = 8'hFF;
    repeat (6) @(negedge iClk);
    iTxReq = 1'b0; iRxReq = 1'b0;
    wait_done(40, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL coll_done_timeout: got none want oTxDone"); end
    else begin
      ev = dq.pop_front(); e = eq.pop_front();
      lat = int'((ev.t - t_acc - 64'd5) / 64'd10);
      n_cmp++; if (ev.tx !== 1'b1 || ev.rx !== 1'b0) begin n_mis++; $display("FAIL coll_pulse: got tx=%b rx=%b want tx=1 rx=0", ev.tx, ev.rx); end
      n_cmp++; if (lat != int'(e.lat)) begin n_mis++; $display("FAIL coll_latency: got %0d want %0d", lat, e.lat); end
      n_cmp++; if (sq.size() != int'(e.ns)) begin n_mis++; $display("FAIL coll_strobe_count: got %0d want %0d", sq.size(), e.ns); end
      if (sq.size() >= 3) begin
        n_cmp++; if (sq[0].pd !== 4'h2 || sq[1].pd !== 4'hE || sq[2].pd !== 4'h3) begin n_mis++; $display("FAIL coll_nibbles: got %h %h %h want 2 e 3", sq[0].pd, sq[1].pd, sq[2].pd); end
      end
    end
    repeat (30) @(posedge iClk); #1;
    n_cmp++; if (dq.size() != 0) begin n_mis++; $display("FAIL coll_extra_pulse: got %0d pulses want 0", dq.size()); end
  endtask

  // Reset in the middle of the LO strobe of a send.
  task automatic test_reset_mid();
    bit found;
    sq.delete(); dq.delete(); eq.delete();
    @(negedge iClk); iTxReq = 1'b1; iTxData = 8'hA5;
    @(posedge iClk); #1; iTxReq = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      if (oCtrl === 5'b00101) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_mis++; $display("FAIL rstmid_lo_seen: got none want LO strobe"); end
    iRst = 1'b1;
    @(negedge iClk);
    n_cmp++; if (oCtrl !== 5'b0 || oBusy !== 1'b0 || oTxDone !== 1'b0) begin n_mis++; $display("FAIL rstmid_outputs: got ctrl=%b busy=%b done=%b want 00000 0 0", oCtrl, oBusy, oTxDone); end
    n_cmp++; if (oPData !== 4'h0) begin n_mis++; $display("FAIL rstmid_pdata: got %h want 0", oPData); end
    iRst = 1'b0;
    repeat (20) @(negedge iClk);
    n_cmp++; if (dq.size() != 0 || oBusy !== 1'b0) begin n_mis++; $display("FAIL rstmid_no_pulse: got %0d pulses busy=%b want 0 0", dq.size(), oBusy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send(8'h5C);
    test_read(8'h03, 8'hA7);
    test_read(8'h80, 8'h55);
    test_collision();
    test_reset_mid();
    test_send(8'h81);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
